// File: rtl/spi_master_apb.sv
// APB SPI master: a register-mode shifter (1-32 bit characters) plus an
// execute-in-place window that turns APB reads into SPI READ (0x03) transactions.
module spi_master_apb #(
  parameter logic [31:0] flash_addr_start = 32'h3000_0000,
  parameter logic [31:0] flash_addr_end   = 32'h3fff_ffff,
  parameter int unsigned spi_cs_num       = 2,
  parameter int unsigned xip_cs           = 0,
  parameter int unsigned div_width        = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [31:0]           in_paddr,
  input  logic                  in_psel,
  input  logic                  in_penable,
  input  logic                  in_pwrite,
  input  logic [2:0]            in_pprot,
  input  logic [31:0]           in_pwdata,
  input  logic [3:0]            in_pstrb,
  output logic                  in_pready,
  output logic [31:0]           in_prdata,
  output logic                  in_pslverr,
  output logic                  spi_clk,
  output logic [spi_cs_num-1:0] spi_cs,
  output logic                  spi_mosi,
  input  logic                  spi_miso,
  output logic                  spi_irq_out
);

  typedef enum logic [1:0] {StIdle, StReg, StXip, StXdone} state_e;

  localparam logic [spi_cs_num-1:0] xip_sel = spi_cs_num'(1) << xip_cs;

  state_e                state_q, state_d;
  logic [31:0]           tx_q, rx_q, xip_sr_q;
  logic [5:0]            char_len_q;
  logic                  lsb_first_q, ass_q, ie_q, irq_q, sck_q;
  logic [div_width-1:0]  div_q, div_cnt_q;
  logic [spi_cs_num-1:0] ss_q;
  logic [6:0]            bit_cnt_q;

  logic        acc, is_xip, reg_acc, wr, wr_ok, busy, go, xip_start;
  logic        active, tick, rise, fall, reg_done, xip_done;
  logic [2:0]  reg_off;
  logic [31:0] wmask, rdata;
  logic [5:0]  len6, msb_idx;
  logic [6:0]  len7;
  logic [4:0]  idx;
  logic        unused_sig;

  assign acc       = in_psel & in_penable;
  assign is_xip    = (in_paddr >= flash_addr_start) && (in_paddr <= flash_addr_end);
  assign reg_acc   = acc & ~is_xip;
  assign reg_off   = in_paddr[4:2];
  assign busy      = (state_q != StIdle);
  assign wr        = reg_acc & in_pwrite;
  assign wr_ok     = wr & ~busy;
  assign go        = wr_ok & (reg_off == 3'd1) & in_pstrb[1] & in_pwdata[8];
  assign xip_start = (state_q == StIdle) & acc & is_xip & ~in_pwrite;
  assign wmask     = {{8{in_pstrb[3]}}, {8{in_pstrb[2]}}, {8{in_pstrb[1]}}, {8{in_pstrb[0]}}};

  // char_len of 0 encodes a 32-bit character
  assign len6    = (char_len_q == 6'd0) ? 6'd32 : char_len_q;
  assign len7    = {1'b0, len6};
  assign msb_idx = len6 - 6'd1 - bit_cnt_q[5:0];
  assign idx     = lsb_first_q ? bit_cnt_q[4:0] : msb_idx[4:0];

  assign active   = (state_q == StReg) || (state_q == StXip);
  assign tick     = (div_cnt_q == div_q);
  assign rise     = active & tick & ~sck_q;
  assign fall     = active & tick & sck_q;
  assign reg_done = (state_q == StReg) & fall & (bit_cnt_q == len7 - 7'd1);
  assign xip_done = (state_q == StXip) & fall & (bit_cnt_q == 7'd63);

  assign unused_sig = ^{in_pprot, msb_idx[5]};

  // Next-state logic for the transfer sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (go)             state_d = StReg;
        else if (xip_start) state_d = StXip;
      end
      StReg:   if (reg_done) state_d = StIdle;
      StXip:   if (xip_done) state_d = StXdone;
      StXdone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // SCK generator, bit counter and receive/XIP shift registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sck_q     <= 1'b0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      xip_sr_q  <= '0;
    end else begin
      if (go || xip_start) begin
        sck_q     <= 1'b0;
        div_cnt_q <= '0;
        bit_cnt_q <= '0;
      end else if (active) begin
        if (tick) begin
          div_cnt_q <= '0;
          sck_q     <= ~sck_q;
          if (sck_q) bit_cnt_q <= bit_cnt_q + 7'd1;
        end else begin
          div_cnt_q <= div_cnt_q + div_width'(1);
        end
      end
      if (go)                              rx_q      <= '0;
      else if ((state_q == StReg) && rise) rx_q[idx] <= spi_miso;
      // Command/address shifts out of the top; the data word then shifts in behind it
      if (xip_start) begin
        xip_sr_q <= {8'h03, in_paddr[23:0]};
      end else if (state_q == StXip) begin
        if (fall && (bit_cnt_q < 7'd32))       xip_sr_q <= {xip_sr_q[30:0], 1'b0};
        else if (rise && (bit_cnt_q >= 7'd32)) xip_sr_q <= {xip_sr_q[30:0], spi_miso};
      end
    end
  end

  // Software-visible registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_q        <= '0;
      char_len_q  <= '0;
      lsb_first_q <= 1'b0;
      ass_q       <= 1'b0;
      ie_q        <= 1'b0;
      div_q       <= '0;
      ss_q        <= '0;
      irq_q       <= 1'b0;
    end else begin
      if (wr_ok && (reg_off == 3'd0)) tx_q <= (tx_q & ~wmask) | (in_pwdata & wmask);
      if (wr_ok && (reg_off == 3'd1)) begin
        if (in_pstrb[0]) char_len_q <= in_pwdata[5:0];
        if (in_pstrb[1]) begin
          lsb_first_q <= in_pwdata[9];
          ass_q       <= in_pwdata[10];
          ie_q        <= in_pwdata[11];
        end
      end
      if (wr_ok && (reg_off == 3'd2)) begin
        div_q <= (div_q & ~wmask[div_width-1:0]) | (in_pwdata[div_width-1:0] & wmask[div_width-1:0]);
      end
      if (wr && (reg_off == 3'd3)) begin
        ss_q <= (ss_q & ~wmask[spi_cs_num-1:0]) |
                (in_pwdata[spi_cs_num-1:0] & wmask[spi_cs_num-1:0]);
      end
      // Completion wins over a simultaneous clear
      if (reg_done) irq_q <= 1'b1;
      else if (wr && (reg_off == 3'd4) && in_pstrb[0] && in_pwdata[1]) irq_q <= 1'b0;
    end
  end

  // Register read mux
  always_comb begin
    rdata = '0;
    case (reg_off)
      3'd0:    rdata = rx_q;
      3'd1:    rdata = {20'b0, ie_q, ass_q, lsb_first_q, busy, 2'b0, char_len_q};
      3'd2:    rdata = 32'(div_q);
      3'd3:    rdata = 32'(ss_q);
      3'd4:    rdata = {30'b0, irq_q, busy};
      default: rdata = '0;
    endcase
  end

  // APB response: registers and XIP writes are zero-wait, XIP reads finish in StXdone
  always_comb begin
    in_pready  = 1'b0;
    in_pslverr = 1'b0;
    in_prdata  = '0;
    if (reg_acc) begin
      in_pready  = 1'b1;
      in_pslverr = wr & busy & (reg_off <= 3'd2);
      if (!in_pwrite) in_prdata = rdata;
    end else if (acc && in_pwrite) begin
      in_pready  = 1'b1;
      in_pslverr = 1'b1;
    end else if (acc && (state_q == StXdone)) begin
      in_pready = 1'b1;
      in_prdata = {xip_sr_q[7:0], xip_sr_q[15:8], xip_sr_q[23:16], xip_sr_q[31:24]};
    end
  end

  // SPI pad outputs
  always_comb begin
    spi_clk     = sck_q;
    spi_irq_out = irq_q & ie_q;
    spi_mosi    = 1'b0;
    spi_cs      = ~ss_q;
    case (state_q)
      StReg:   spi_mosi = tx_q[idx];
      StXip: begin
        spi_mosi = (bit_cnt_q < 7'd32) & xip_sr_q[31];
        spi_cs   = ~xip_sel;
      end
      StXdone: spi_cs = '1;
      default: if (ass_q) spi_cs = '1;
    endcase
  end

endmodule

// File: tb/tb_spi_master_apb.sv
// Randomized self-checking bench for spi_master_apb with a bit-level slave model.
module tb_spi_master_apb;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] paddr = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [2:0]  pprot = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic        spi_clk, spi_mosi, spi_miso, spi_irq;
  logic [1:0]  spi_cs;

  spi_master_apb dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_paddr    (paddr),
    .in_psel     (psel),
    .in_penable  (penable),
    .in_pwrite   (pwrite),
    .in_pprot    (pprot),
    .in_pwdata   (pwdata),
    .in_pstrb    (pstrb),
    .in_pready   (pready),
    .in_prdata   (prdata),
    .in_pslverr  (pslverr),
    .spi_clk     (spi_clk),
    .spi_cs      (spi_cs),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_irq_out (spi_irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Slave / line monitor state
  logic        loop_mode = 1'b0;
  logic [63:0] slave_vec = '0;
  logic        miso_slave = 1'b0;
  logic        sck_prev = 1'b0;
  int          rise_cnt = 0;
  int          cs_low_cyc = 0;
  int          rdy_cyc = 0;
  int          sck_rises = 0;
  bit          mosi_q[$];

  logic [31:0] r_data;
  logic        r_err;
  int          r_waits;

  assign spi_miso = loop_mode ? spi_mosi : miso_slave;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Mode-0 slave: presents bit k before the k-th SCK rise of the current CS session
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (spi_clk && !sck_prev) sck_rises++;
      if (spi_cs == 2'b11) begin
        rise_cnt = 0;
      end else if (spi_clk && !sck_prev) begin
        mosi_q.push_back(spi_mosi);
        rise_cnt++;
      end
      sck_prev = spi_clk;
      if (!spi_cs[0]) cs_low_cyc++;
      if (pready) rdy_cyc++;
      miso_slave = (rise_cnt < 64) ? slave_vec[63-rise_cnt] : 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic apb(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output logic err,
                     output int waits);
    @(negedge clk);
    paddr = a; pwrite = w; pwdata = d; pstrb = s; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    waits = 0;
    #1;
    while (!pready && waits < 5000) begin
      @(negedge clk);
      #1;
      waits++;
    end
    check("pready", pready, 1);
    rd = prdata;
    err = pslverr;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    apb(a, 1'b1, d, 4'hf, r_data, r_err, r_waits);
  endtask

  task automatic rd(input logic [31:0] a);
    apb(a, 1'b0, 32'h0, 4'hf, r_data, r_err, r_waits);
  endtask

  task automatic wait_idle();
    int n = 0;
    rd(32'h10);
    while (r_data[0] && n < 3000) begin
      rd(32'h10);
      n++;
    end
    check("idle", r_data[0], 0);
  endtask

  // One register-mode character against the reference bit ordering
  task automatic run_reg(input logic [31:0] data, input int len, input logic lsb,
                         input int div, input logic ie, input logic loop);
    logic [63:0] exp_seq, got_seq;
    logic [31:0] exp_rx, ctrl;
    int nb, pos;
    loop_mode = loop;
    slave_vec = {$urandom, $urandom};
    wr(32'h08, div);
    wr(32'h00, data);
    ctrl = 32'(len % 32);
    ctrl[8] = 1'b1;
    ctrl[9] = lsb;
    ctrl[10] = 1'b1;
    ctrl[11] = ie;
    exp_seq = '0;
    exp_rx = '0;
    for (int k = 0; k < len; k++) begin
      pos = lsb ? k : len - 1 - k;
      exp_seq[k] = data[pos];
      exp_rx[pos] = loop ? data[pos] : slave_vec[63-k];
    end
    mosi_q.delete();
    cs_low_cyc = 0;
    wr(32'h04, ctrl);
    check("go_err", r_err, 0);
    wait_idle();
    check("irq_pend", r_data[1], 1);
    check("irq_line", spi_irq, ie);
    nb = mosi_q.size();
    check("nbits", nb, len);
    got_seq = '0;
    for (int k = 0; k < nb && k < 64; k++) got_seq[k] = mosi_q[k];
    check("mosi_seq", got_seq, exp_seq);
    check("busy_cycles", cs_low_cyc, len * 2 * (div + 1));
    rd(32'h00);
    check("rx_data", r_data, exp_rx);
    wr(32'h10, 32'h2);
    check("irq_clear", spi_irq, 0);
  endtask

  // One XIP read; stream holds the slave's data bytes in send order (b0 in [31:24])
  task automatic run_xip(input logic [31:0] addr, input logic [31:0] stream, input int div);
    logic [31:0] cmd, exp;
    int nb;
    wr(32'h08, div);
    loop_mode = 1'b0;
    slave_vec = {$urandom, stream};
    exp = {stream[7:0], stream[15:8], stream[23:16], stream[31:24]};
    mosi_q.delete();
    cs_low_cyc = 0;
    rdy_cyc = 0;
    rd(addr);
    check("xip_err", r_err, 0);
    check("xip_data", r_data, exp);
    check("xip_latency", r_waits, 1 + 128 * (div + 1));
    @(negedge clk);
    #3;
    check("xip_rdy_cycles", rdy_cyc, 1);
    check("xip_cs_low", cs_low_cyc, 128 * (div + 1));
    check("xip_cs_idle", spi_cs, 2'b11);
    nb = mosi_q.size();
    check("xip_nbits", nb, 64);
    cmd = '0;
    for (int k = 0; k < 32 && k < nb; k++) cmd = {cmd[30:0], mosi_q[k]};
    check("xip_cmd", cmd, {8'h03, addr[23:0]});
  endtask

  initial begin
    int snap;
    #12;
    check("rst_sck", spi_clk, 0);
    check("rst_cs", spi_cs, 2'b11);
    check("rst_mosi", spi_mosi, 0);
    check("rst_irq", spi_irq, 0);
    check("rst_pready", pready, 0);
    check("rst_prdata", prdata, 0);
    check("rst_pslverr", pslverr, 0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd(32'(i * 4));
      check("rst_reg", r_data, 0);
    end

    // Auto slave-select on slave 0
    wr(32'h04, 32'h0000_0408);
    wr(32'h0C, 32'h1);

    // Loopback 0xA5, 8 bits MSB-first, DIV=0
    run_reg(32'h0000_00A5, 8, 1'b0, 0, 1'b0, 1'b1);
    // 32 bits LSB-first, DIV=3, interrupt enabled
    run_reg(32'h8000_0001, 32, 1'b1, 3, 1'b1, 1'b0);
    repeat (6) begin
      run_reg($urandom, $urandom_range(1, 32), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // XIP reads
    run_xip(32'h3012_3456, 32'h1122_3344, 0);
    repeat (3) begin
      run_xip(32'h3000_0000 | ($urandom & 32'h0fff_fffc), $urandom, $urandom_range(0, 2));
    end

    // XIP write: immediate error, no SCK
    snap = sck_rises;
    apb(32'h3000_0000, 1'b1, 32'hdead_beef, 4'hf, r_data, r_err, r_waits);
    check("xipwr_waits", r_waits, 0);
    check("xipwr_err", r_err, 1);
    repeat (5) @(negedge clk);
    #3;
    check("xipwr_nosck", sck_rises, snap);

    // Undecoded offsets
    rd(32'h14);
    check("undec_rd", r_data, 0);
    wr(32'h18, 32'hffff_ffff);
    check("undec_wr_err", r_err, 0);

    // Busy register transfer: locked writes, then a stalled XIP read
    loop_mode = 1'b0;
    wr(32'h08, 32'h1);
    wr(32'h00, $urandom);
    wr(32'h04, 32'h0000_0500);
    wr(32'h04, 32'h0000_0005);
    check("ctrl_locked_err", r_err, 1);
    rd(32'h04);
    check("ctrl_unchanged", r_data, 32'h0000_0500);
    wr(32'h08, 32'h7);
    check("div_locked_err", r_err, 1);
    wr(32'h0C, 32'h1);
    check("ss_busy_err", r_err, 0);
    slave_vec = {32'h0, 32'hA1B2_C3D4};
    rd(32'h3000_0100);
    check("stall_err", r_err, 0);
    check("stall_data", r_data, 32'hD4C3_B2A1);
    check("stalled", r_waits > 1 + 128 * 2, 1);
    rd(32'h08);
    check("div_unchanged", r_data, 1);
    wr(32'h10, 32'h2);

    // Reset in the middle of an XIP read
    wr(32'h08, 32'h2);
    @(negedge clk);
    paddr = 32'h3000_0040; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    repeat (41) @(negedge clk);
    check("xip_cs_active", spi_cs[0], 0);
    #3;
    resetn = 1'b0;
    #1;
    check("arst_cs", spi_cs, 2'b11);
    check("arst_sck", spi_clk, 0);
    check("arst_pready", pready, 0);
    psel = 1'b0; penable = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    rd(32'h08);
    check("post_rst_div", r_data, 0);
    check("post_rst_waits", r_waits, 0);
    wr(32'h08, 32'h5);
    rd(32'h08);
    check("post_rst_div_wr", r_data, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
